// File: rtl/video_pkg.sv
// Shared types and constants for the stream-to-video timing source.
package video_pkg;

  // Source FSM states
  typedef enum logic [2:0] {
    IDLE,
    SEEK_SOF,
    WAIT_FRAME,
    RUN,
    FLUSH
  } vtx_state_e;

  // Bit positions inside the sticky status vector
  localparam int unsigned STAT_UNDERFLOW = 0;
  localparam int unsigned STAT_SOF_ERR   = 1;
  localparam int unsigned STAT_EOL_ERR   = 2;
  localparam int unsigned STAT_W         = 3;

  // Width of the timing counters and config words
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/video_timing_cnt.sv
// Free-running line/frame counters with per-frame latched configuration.
module video_timing_cnt
  import video_pkg::*;
#(
  parameter string DEBUG = "FALSE"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_h_act,
  input  logic [CNT_W-1:0] i_h_ofs,
  input  logic [CNT_W-1:0] i_h_total,
  input  logic [CNT_W-1:0] i_v_act,
  input  logic [CNT_W-1:0] i_v_total,
  output logic             o_act,
  output logic             o_vs_line,
  output logic             o_first_act,
  output logic             o_last_act,
  output logic             o_frame_start,
  output logic             o_frame_end
);

  logic [CNT_W-1:0] r_hcnt, r_vcnt;
  logic [CNT_W-1:0] r_h_act, r_h_ofs, r_h_total, r_v_act, r_v_total;

  logic [CNT_W-1:0] w_h_act, w_h_ofs, w_h_total, w_v_act, w_v_total;
  logic             w_frame_start, w_h_wrap, w_v_wrap, w_vs_line, w_act;
  logic [CNT_W:0]   w_h_end;

  // Frame-start cycle sees the live ports so the whole frame runs on one config set
  always_comb begin
    w_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
    w_h_act       = w_frame_start ? i_h_act   : r_h_act;
    w_h_ofs       = w_frame_start ? i_h_ofs   : r_h_ofs;
    w_h_total     = w_frame_start ? i_h_total : r_h_total;
    w_v_act       = w_frame_start ? i_v_act   : r_v_act;
    w_v_total     = w_frame_start ? i_v_total : r_v_total;
    // 17-bit sums so H_OFS+H_ACT cannot wrap
    w_h_end       = {1'b0, w_h_ofs} + {1'b0, w_h_act};
    w_h_wrap      = ({1'b0, r_hcnt} + 17'd1) == {1'b0, w_h_total};
    w_v_wrap      = ({1'b0, r_vcnt} + 17'd1) == {1'b0, w_v_total};
    w_vs_line     = (r_vcnt != '0) && (r_vcnt <= w_v_act);
    w_act         = w_vs_line && (r_hcnt >= w_h_ofs) && ({1'b0, r_hcnt} < w_h_end);
  end

  assign o_act         = w_act;
  assign o_vs_line     = w_vs_line;
  assign o_first_act   = w_act && (r_vcnt == 16'd1) && (r_hcnt == w_h_ofs);
  assign o_last_act    = w_act && (({1'b0, r_hcnt} + 17'd1) == w_h_end);
  assign o_frame_start = w_frame_start;
  assign o_frame_end   = w_h_wrap && w_v_wrap;

  // Config latch at frame start and the hcnt/vcnt raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_h_act   <= '0;
      r_h_ofs   <= '0;
      r_h_total <= '0;
      r_v_act   <= '0;
      r_v_total <= '0;
    end else begin
      if (w_frame_start) begin
        r_h_act   <= i_h_act;
        r_h_ofs   <= i_h_ofs;
        r_h_total <= i_h_total;
        r_v_act   <= i_v_act;
        r_v_total <= i_v_total;
      end
      if (!i_run) begin
        r_hcnt <= '0;
        r_vcnt <= '0;
      end else if (w_h_wrap) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_wrap ? '0 : r_vcnt + 16'd1;
      end else begin
        r_hcnt <= r_hcnt + 16'd1;
      end
    end
  end

  if (DEBUG == "TRUE") begin : g_debug
    (* mark_debug = "true" *) logic [CNT_W-1:0] r_dbg_hcnt;
    (* mark_debug = "true" *) logic [CNT_W-1:0] r_dbg_vcnt;
    // Probe copies of the raster position
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dbg_hcnt <= '0;
        r_dbg_vcnt <= '0;
      end else begin
        r_dbg_hcnt <= r_hcnt;
        r_dbg_vcnt <= r_vcnt;
      end
    end
  end

endmodule

// File: rtl/axis_to_video.sv
// AXI4-Stream to en/vs video source: frame-locks on tuser, checks tlast and keeps
// the output raster running through underflow and stream errors.
module axis_to_video
  import video_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] FILL       = '0,
  parameter string                 DEBUG      = "FALSE"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      H_ACT,
  input  logic [CNT_W-1:0]      H_OFS,
  input  logic [CNT_W-1:0]      H_TOTAL,
  input  logic [CNT_W-1:0]      V_ACT,
  input  logic [CNT_W-1:0]      V_TOTAL,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tuser,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  en_out,
  output logic                  vs_out,
  output logic [STAT_W-1:0]     status
);

  vtx_state_e              r_state;
  logic                    r_vs, r_en;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic [STAT_W-1:0]       r_status;

  logic                    w_act, w_vs_line, w_first_act, w_last_act;
  logic                    w_frame_start, w_frame_end;
  logic                    w_run_act, w_take;
  logic [STAT_W-1:0]       w_err;

  video_timing_cnt #(
    .DEBUG (DEBUG)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_run         (r_state != IDLE),
    .i_h_act       (H_ACT),
    .i_h_ofs       (H_OFS),
    .i_h_total     (H_TOTAL),
    .i_v_act       (V_ACT),
    .i_v_total     (V_TOTAL),
    .o_act         (w_act),
    .o_vs_line     (w_vs_line),
    .o_first_act   (w_first_act),
    .o_last_act    (w_last_act),
    .o_frame_start (w_frame_start),
    .o_frame_end   (w_frame_end)
  );

  // Stream ready per state and error detection on active RUN pixels
  always_comb begin
    unique case (r_state)
      IDLE:       s_tready = 1'b0;
      SEEK_SOF:   s_tready = !s_tuser;  // hold the SOF beat for the next frame
      WAIT_FRAME: s_tready = 1'b0;
      RUN:        s_tready = w_act;
      FLUSH:      s_tready = 1'b0;
      default:    s_tready = 1'b0;
    endcase
    w_run_act                  = (r_state == RUN) && w_act;
    w_take                     = w_run_act && s_tvalid;
    w_err                      = '0;
    w_err[STAT_UNDERFLOW]      = w_run_act && !s_tvalid;
    w_err[STAT_SOF_ERR]        = w_take && s_tuser && !w_first_act;
    w_err[STAT_EOL_ERR]        = w_take && (s_tlast != w_last_act);
  end

  // Source FSM; enable only acts on frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (enable) r_state <= SEEK_SOF;
        end
        SEEK_SOF: begin
          if (w_frame_end && !enable)   r_state <= IDLE;
          else if (s_tvalid && s_tuser) r_state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (w_frame_end && !enable) r_state <= IDLE;
          else if (w_frame_start)     r_state <= RUN;
        end
        RUN: begin
          if (w_frame_end && !enable) r_state <= IDLE;
          else if (|w_err)            r_state <= FLUSH;
        end
        FLUSH: begin
          if (w_frame_end) r_state <= enable ? SEEK_SOF : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Registered video outputs and sticky per-frame status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs     <= 1'b0;
      r_en     <= 1'b0;
      r_dout   <= '0;
      r_status <= '0;
    end else begin
      r_vs   <= w_vs_line;
      r_en   <= w_act;
      r_dout <= w_take ? s_tdata : FILL;
      if (w_frame_start) r_status <= '0;
      else               r_status <= r_status | w_err;
    end
  end

  assign vs_out = r_vs;
  assign en_out = r_en;
  assign dout   = r_dout;
  assign status = r_status;

  if (DEBUG == "TRUE") begin : g_debug
    (* mark_debug = "true" *) vtx_state_e        r_dbg_state;
    (* mark_debug = "true" *) logic [STAT_W-1:0] r_dbg_status;
    // Probe copies of FSM state and status
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dbg_state  <= IDLE;
        r_dbg_status <= '0;
      end else begin
        r_dbg_state  <= r_state;
        r_dbg_status <= r_status;
      end
    end
  end

endmodule

// File: tb/tb_axis_to_video.sv
// Scoreboard bench for axis_to_video: expected pixels/status queued with stimulus.
module tb_axis_to_video;

  localparam logic [15:0] FILL_V = 16'hBEEF;
  localparam int          HOFS   = 2;
  localparam int          VACT   = 3;

  typedef struct packed {
    logic [15:0] d;
    logic        u;
    logic        l;
    logic        gap;
    logic        junk;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] H_ACT = 16'd4, H_OFS = 16'd2, H_TOTAL = 16'd8, V_ACT = 16'd3, V_TOTAL = 16'd5;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic        s_tready;
  logic [15:0] dout;
  logic        en_out, vs_out;
  logic [2:0]  status;

  axis_to_video #(
    .DATA_WIDTH (16),
    .FILL       (FILL_V),
    .DEBUG      ("FALSE")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .H_ACT    (H_ACT),
    .H_OFS    (H_OFS),
    .H_TOTAL  (H_TOTAL),
    .V_ACT    (V_ACT),
    .V_TOTAL  (V_TOTAL),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tuser  (s_tuser),
    .s_tlast  (s_tlast),
    .dout     (dout),
    .en_out   (en_out),
    .vs_out   (vs_out),
    .status   (status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  beat_t       src_q[$];
  logic [15:0] px_q[$];
  logic [2:0]  st_q[$];

  bit mon_en = 0;
  bit auto_drop = 0;
  bit vs_prev = 0;
  int vs_k = 0;
  int cur_hact = 4, cur_htot = 8, nxt_hact = 4, nxt_htot = 8;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: raster position, frame length, pixels and status per frame
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (vs_out) begin
        int pos;
        if (!vs_prev) begin
          cur_hact = nxt_hact;
          cur_htot = nxt_htot;
          vs_k = 0;
        end else begin
          vs_k++;
        end
        pos = vs_k % cur_htot;
        check_eq("en_pos", int'(en_out), int'(pos >= HOFS && pos < HOFS + cur_hact));
      end else begin
        if (vs_prev) begin
          check_eq("vs_len", vs_k + 1, VACT * cur_htot);
          if (st_q.size() == 0) check_eq("st_extra", int'(vs_prev), 0);
          else check_eq("status", int'(status), int'(st_q.pop_front()));
        end
        check_eq("en_novs", int'(en_out), 0);
      end
      if (en_out) begin
        if (px_q.size() == 0) check_eq("px_extra", int'(en_out), 0);
        else check_eq("dout", int'(dout), int'(px_q.pop_front()));
      end
      vs_prev = vs_out;
    end
  end

  // One clock: present head beat, judge handshake at negedge, pop after posedge
  task automatic step();
    beat_t b;
    bit    have, hs;
    have = (src_q.size() > 0);
    b = '0;
    if (have) b = src_q[0];
    s_tvalid = have && !b.gap;
    s_tdata  = b.d;
    s_tuser  = have && b.u;
    s_tlast  = have && b.l;
    @(negedge clk);
    hs = 0;
    if (have) begin
      if (b.junk) check_eq("junk_rdy", int'(s_tready), 1);
      hs = s_tready && (b.gap || s_tvalid);
    end
    @(posedge clk);
    #1;
    if (hs) void'(src_q.pop_front());
    if (auto_drop && src_q.size() == 0) enable = 0;
  endtask

  task automatic add_frame(input logic [15:0] base, input int hact, input int bad_last,
                           input int gap_at);
    beat_t b;
    for (int i = 0; i < hact * VACT; i++) begin
      if (i == gap_at) begin
        b = '0;
        b.gap = 1'b1;
        src_q.push_back(b);
      end
      b = '0;
      b.d = base + 16'(i);
      b.u = (i == 0);
      b.l = ((i % hact) == hact - 1) || (i == bad_last);
      src_q.push_back(b);
    end
  endtask

  task automatic exp_px(input logic [15:0] base, input int n, input bit fill);
    for (int i = 0; i < n; i++) px_q.push_back(fill ? FILL_V : base + 16'(i));
  endtask

  task automatic apply_reset();
    mon_en = 0;
    auto_drop = 0;
    enable = 0;
    s_tvalid = 0;
    s_tuser = 0;
    s_tlast = 0;
    H_ACT = 16'd4;
    H_OFS = 16'd2;
    H_TOTAL = 16'd8;
    V_ACT = 16'd3;
    V_TOTAL = 16'd5;
    nxt_hact = 4;
    nxt_htot = 8;
    src_q.delete();
    px_q.delete();
    st_q.delete();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    vs_prev = 0;
  endtask

  task automatic start_scn();
    apply_reset();
    mon_en = 1;
    enable = 1;
    step();
  endtask

  task automatic finish_scn(input int chg_at);
    int cyc;
    cyc = 0;
    auto_drop = 1;
    while (enable && cyc < 800) begin
      if (cyc == chg_at) begin
        H_ACT = 16'd6;
        H_TOTAL = 16'd10;
        nxt_hact = 6;
        nxt_htot = 10;
      end
      step();
      cyc++;
    end
    check_eq("drop_timeout", int'(enable), 0);
    enable = 0;
    repeat (100) step();
    check_eq("px_left", px_q.size(), 0);
    check_eq("st_left", st_q.size(), 0);
    check_eq("src_left", src_q.size(), 0);
    @(negedge clk);
    check_eq("idle_vs", int'(vs_out), 0);
    check_eq("idle_en", int'(en_out), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    apply_reset();
    @(negedge clk);
    check_eq("rst_vs", int'(vs_out), 0);
    check_eq("rst_en", int'(en_out), 0);
    check_eq("rst_dout", int'(dout), 0);
    check_eq("rst_status", int'(status), 0);
    check_eq("rst_rdy", int'(s_tready), 0);

    // Clean stream, two data frames, enable dropped mid second frame
    start_scn();
    add_frame(16'h0100, 4, -1, -1);
    add_frame(16'h0200, 4, -1, -1);
    exp_px('0, 12, 1);
    exp_px(16'h0100, 12, 0);
    exp_px(16'h0200, 12, 0);
    st_q.push_back(3'b000); st_q.push_back(3'b000); st_q.push_back(3'b000);
    finish_scn(-1);

    // Junk beats ahead of SOF are dropped
    start_scn();
    for (int i = 0; i < 5; i++) begin
      beat_t b;
      b = '0;
      b.d = 16'h0A00 + 16'(i);
      b.junk = 1'b1;
      src_q.push_back(b);
    end
    add_frame(16'h0300, 4, -1, -1);
    exp_px('0, 12, 1);
    exp_px(16'h0300, 12, 0);
    st_q.push_back(3'b000); st_q.push_back(3'b000);
    finish_scn(-1);

    // Underflow on line 2 pixel 1, then resync
    start_scn();
    add_frame(16'h0400, 4, -1, 5);
    add_frame(16'h0500, 4, -1, -1);
    exp_px('0, 12, 1);
    exp_px(16'h0400, 5, 0);
    exp_px('0, 7, 1);
    exp_px('0, 12, 1);
    exp_px(16'h0500, 12, 0);
    st_q.push_back(3'b000); st_q.push_back(3'b001);
    st_q.push_back(3'b000); st_q.push_back(3'b000);
    finish_scn(-1);

    // Early tlast on pixel 2 of line 1
    start_scn();
    add_frame(16'h0600, 4, 2, -1);
    add_frame(16'h0700, 4, -1, -1);
    exp_px('0, 12, 1);
    exp_px(16'h0600, 3, 0);
    exp_px('0, 9, 1);
    exp_px('0, 12, 1);
    exp_px(16'h0700, 12, 0);
    st_q.push_back(3'b000); st_q.push_back(3'b100);
    st_q.push_back(3'b000); st_q.push_back(3'b000);
    finish_scn(-1);

    // Mid-frame config change applies from the next frame
    start_scn();
    add_frame(16'h0800, 4, -1, -1);
    add_frame(16'h0900, 6, -1, -1);
    exp_px('0, 12, 1);
    exp_px(16'h0800, 12, 0);
    exp_px(16'h0900, 18, 0);
    st_q.push_back(3'b000); st_q.push_back(3'b000); st_q.push_back(3'b000);
    finish_scn(59);

    // Asynchronous reset mid-line, then IDLE -> SEEK_SOF
    start_scn();
    mon_en = 0;
    add_frame(16'h0B00, 4, -1, -1);
    repeat (60) step();
    check_eq("pre_rst_vs", int'(vs_out), 1);
    #1;
    rst_n = 0;
    #1;
    check_eq("arst_vs", int'(vs_out), 0);
    check_eq("arst_en", int'(en_out), 0);
    check_eq("arst_dout", int'(dout), 0);
    check_eq("arst_status", int'(status), 0);
    check_eq("arst_rdy", int'(s_tready), 0);
    #1;
    rst_n = 1;
    src_q.delete();
    s_tvalid = 1;
    s_tuser = 0;
    s_tdata = 16'h0C00;
    #1;
    check_eq("idle_rdy", int'(s_tready), 0);
    @(posedge clk);
    #1;
    check_eq("seek_rdy", int'(s_tready), 1);
    s_tvalid = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
